// File: rtl/hazard3_instr_aligner_if.sv
// Fetch-side and decode-side signals of the halfword instruction aligner.
// master drives fetch data and retire counts; slave is the aligner itself.
interface hazard3_instr_aligner_if;
  logic        fetch_vld;
  logic        fetch_rdy;
  logic [31:0] fetch_data;
  logic        fetch_err;
  logic        flush;
  logic        flush_addr_hw;
  logic [31:0] cir;
  logic [1:0]  cir_vld;
  logic [1:0]  cir_err;
  logic [1:0]  cir_use;

  modport master (
    output fetch_vld, fetch_data, fetch_err, flush, flush_addr_hw, cir_use,
    input  fetch_rdy, cir, cir_vld, cir_err
  );

  modport slave (
    input  fetch_vld, fetch_data, fetch_err, flush, flush_addr_hw, cir_use,
    output fetch_rdy, cir, cir_vld, cir_err
  );
endinterface

// File: rtl/hazard3_instr_aligner.sv
// Halfword-granular instruction buffer feeding the RVC expander: accepts
// word-aligned fetch data, handles misaligned jump targets, presents a 32-bit window.
module hazard3_instr_aligner #(
  parameter int unsigned DEPTH_HW = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  hazard3_instr_aligner_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH_HW + 1);

  logic [15:0]         data_q [DEPTH_HW];
  logic [15:0]         data_d [DEPTH_HW];
  logic [DEPTH_HW-1:0] err_q;
  logic [DEPTH_HW-1:0] err_d;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;
  logic                drop_lower_q;
  logic                drop_lower_d;

  logic        fetch_rdy;
  logic        accept;
  int unsigned cnt;
  int unsigned use_n;
  int unsigned base;
  int unsigned appended;

  always_comb begin
    cnt       = 32'(count_q);
    // Readiness deliberately ignores same-cycle retirement to keep decode off the bus path.
    fetch_rdy = (cnt <= DEPTH_HW - 2);
    accept    = bus.fetch_vld && fetch_rdy && !bus.flush;

    use_n = 32'(bus.cir_use);
    if (use_n > 2) use_n = 2;
    if (use_n > cnt) use_n = cnt;
    base = cnt - use_n;

    for (int unsigned i = 0; i < DEPTH_HW; i++) begin
      data_d[i] = '0;
      err_d[i]  = 1'b0;
      for (int unsigned j = 0; j < DEPTH_HW; j++) begin
        if (j == i + use_n) begin
          data_d[i] = data_q[j];
          err_d[i]  = err_q[j];
        end
      end
    end

    appended     = 0;
    drop_lower_d = drop_lower_q;
    if (accept) begin
      drop_lower_d = 1'b0;
      appended     = drop_lower_q ? 1 : 2;
      for (int unsigned i = 0; i < DEPTH_HW; i++) begin
        if (drop_lower_q) begin
          if (i == base) begin
            data_d[i] = bus.fetch_data[31:16];
            err_d[i]  = bus.fetch_err;
          end
        end else begin
          if (i == base) begin
            data_d[i] = bus.fetch_data[15:0];
            err_d[i]  = bus.fetch_err;
          end
          if (i == base + 1) begin
            data_d[i] = bus.fetch_data[31:16];
            err_d[i]  = bus.fetch_err;
          end
        end
      end
    end

    count_d = CW'(base + appended);
    if (bus.flush) begin
      count_d      = '0;
      drop_lower_d = bus.flush_addr_hw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH_HW; i++) data_q[i] <= '0;
      err_q        <= '0;
      count_q      <= '0;
      drop_lower_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH_HW; i++) data_q[i] <= data_d[i];
      err_q        <= err_d;
      count_q      <= count_d;
      drop_lower_q <= drop_lower_d;
    end
  end

  // Stale entries beyond count are masked so invalid halfwords always read as zero.
  always_comb begin
    bus.fetch_rdy = fetch_rdy;
    bus.cir       = '0;
    bus.cir_err   = '0;
    bus.cir_vld   = (cnt >= 2) ? 2'd2 : 2'(cnt);
    if (cnt >= 1) begin
      bus.cir[15:0]  = data_q[0];
      bus.cir_err[0] = err_q[0];
    end
    if (cnt >= 2) begin
      bus.cir[31:16] = data_q[1];
      bus.cir_err[1] = err_q[1];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (bus.cir_use <= bus.cir_vld)
        else $error("cir_use %0d exceeds cir_vld %0d", bus.cir_use, bus.cir_vld);
    end
  end
`endif

endmodule

// File: tb/tb_hazard3_instr_aligner.sv
// Bench for hazard3_instr_aligner: halfword-queue reference model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_hazard3_instr_aligner;
  localparam int unsigned DEPTH = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard3_instr_aligner_if ifc ();

  hazard3_instr_aligner #(.DEPTH_HW(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Reference: queue of {err, halfword}, oldest at the front.
  logic [16:0] mq[$];
  bit          m_drop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_drop = 1'b0;
    end else if (ifc.flush) begin
      mq.delete();
      m_drop = ifc.flush_addr_hw;
    end else begin
      bit rdy;
      rdy = (mq.size() <= int'(DEPTH) - 2);
      for (int k = 0; k < int'(ifc.cir_use) && mq.size() > 0; k++) void'(mq.pop_front());
      if (ifc.fetch_vld && rdy) begin
        if (!m_drop) mq.push_back({ifc.fetch_err, ifc.fetch_data[15:0]});
        mq.push_back({ifc.fetch_err, ifc.fetch_data[31:16]});
        m_drop = 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_cir();
    logic [31:0] r;
    r = '0;
    if (mq.size() > 0) r[15:0]  = mq[0][15:0];
    if (mq.size() > 1) r[31:16] = mq[1][15:0];
    return r;
  endfunction

  function automatic logic [31:0] exp_err();
    logic [31:0] r;
    r = '0;
    if (mq.size() > 0) r[0] = mq[0][16];
    if (mq.size() > 1) r[1] = mq[1][16];
    return r;
  endfunction

  function automatic logic [31:0] exp_vld();
    return (mq.size() >= 2) ? 32'd2 : 32'(mq.size());
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_cir",  ifc.cir,               exp_cir());
      chk("model_vld",  32'(ifc.cir_vld),      exp_vld());
      chk("model_err",  32'(ifc.cir_err),      exp_err());
      chk("model_rdy",  32'(ifc.fetch_rdy),    32'(mq.size() <= int'(DEPTH) - 2));
    end
  end

  task automatic cyc(input bit v, input logic [31:0] d, input bit e,
                     input logic [1:0] u, input bit fl, input bit fa);
    ifc.fetch_vld     = v;
    ifc.fetch_data    = d;
    ifc.fetch_err     = e;
    ifc.cir_use       = u;
    ifc.flush         = fl;
    ifc.flush_addr_hw = fa;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] cir_e, input logic [1:0] vld_e,
                     input logic [1:0] err_e, input bit rdy_e);
    chk({name, "_cir"}, ifc.cir,                cir_e);
    chk({name, "_vld"}, 32'(ifc.cir_vld),       32'(vld_e));
    chk({name, "_err"}, 32'(ifc.cir_err),       32'(err_e));
    chk({name, "_rdy"}, 32'(ifc.fetch_rdy),     32'(rdy_e));
  endtask

  initial begin
    ifc.fetch_vld     = 1'b0;
    ifc.fetch_data    = '0;
    ifc.fetch_err     = 1'b0;
    ifc.cir_use       = '0;
    ifc.flush         = 1'b0;
    ifc.flush_addr_hw = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    lit("reset", 32'h0, 2'd0, 2'b00, 1'b1);

    // Basic word acceptance from empty
    cyc(1, 32'h0001_4501, 0, 2'd0, 0, 0);
    lit("word", 32'h0001_4501, 2'd2, 2'b00, 1'b1);
    cyc(0, 32'h0, 0, 2'd2, 0, 0);
    lit("drain1", 32'h0, 2'd0, 2'b00, 1'b1);

    // One buffered halfword, then a word appended behind it
    cyc(0, 32'h0, 0, 2'd0, 1, 1);
    cyc(1, 32'h4505_1111, 0, 2'd0, 0, 0);
    lit("one_hw", 32'h0000_4505, 2'd1, 2'b00, 1'b1);
    cyc(1, 32'h8082_0513, 0, 2'd0, 0, 0);
    lit("append3", 32'h0513_4505, 2'd2, 2'b00, 1'b1);
    cyc(0, 32'h0, 0, 2'd1, 0, 0);
    lit("retire1", 32'h8082_0513, 2'd2, 2'b00, 1'b1);
    cyc(0, 32'h0, 0, 2'd2, 0, 0);

    // Misaligned jump target drops the lower halfword
    cyc(0, 32'h0, 0, 2'd0, 1, 1);
    cyc(1, 32'h4501_8082, 0, 2'd0, 0, 0);
    lit("misalign", 32'h0000_4501, 2'd1, 2'b00, 1'b1);
    cyc(0, 32'h0, 0, 2'd1, 0, 0);

    // Fill to full, then drain while fetch stays asserted
    cyc(1, 32'hA001_A000, 0, 2'd0, 0, 0);
    cyc(1, 32'hA003_A002, 0, 2'd0, 0, 0);
    lit("fill4", 32'hA001_A000, 2'd2, 2'b00, 1'b1);
    cyc(1, 32'hA005_A004, 0, 2'd0, 0, 0);
    lit("full6", 32'hA001_A000, 2'd2, 2'b00, 1'b0);
    cyc(1, 32'hA007_A006, 0, 2'd0, 0, 0);
    lit("reject6", 32'hA001_A000, 2'd2, 2'b00, 1'b0);
    cyc(1, 32'hA007_A006, 0, 2'd1, 0, 0);
    lit("full5", 32'hA002_A001, 2'd2, 2'b00, 1'b0);
    cyc(1, 32'hA007_A006, 0, 2'd2, 0, 0);
    lit("drain3", 32'hA004_A003, 2'd2, 2'b00, 1'b1);
    cyc(1, 32'hA007_A006, 0, 2'd2, 0, 0);
    lit("refill3", 32'hA006_A005, 2'd2, 2'b00, 1'b1);
    cyc(0, 32'h0, 0, 2'd2, 0, 0);
    lit("tail", 32'h0000_A007, 2'd1, 2'b00, 1'b1);
    cyc(0, 32'h0, 0, 2'd1, 0, 0);

    // Back-to-back flushes; the word with the second flush is discarded
    cyc(0, 32'h0, 0, 2'd0, 1, 1);
    cyc(1, 32'hFFFF_EEEE, 0, 2'd0, 1, 0);
    lit("flush_word", 32'h0, 2'd0, 2'b00, 1'b1);
    cyc(1, 32'h1234_5678, 0, 2'd0, 0, 0);
    lit("after_flush", 32'h1234_5678, 2'd2, 2'b00, 1'b1);
    cyc(0, 32'h0, 0, 2'd2, 0, 0);

    // Bus errors tag halfwords; a dropped lower half takes its tag with it
    cyc(1, 32'hDEAD_BEEF, 1, 2'd0, 0, 0);
    lit("err_full", 32'hDEAD_BEEF, 2'd2, 2'b11, 1'b1);
    cyc(0, 32'h0, 0, 2'd2, 0, 0);
    cyc(0, 32'h0, 0, 2'd0, 1, 1);
    cyc(1, 32'hDEAD_BEEF, 1, 2'd0, 0, 0);
    lit("err_hi", 32'h0000_DEAD, 2'd1, 2'b01, 1'b1);
    cyc(0, 32'h0, 0, 2'd1, 0, 0);

    // Random soak with legal retire amounts
    for (int n = 0; n < 600; n++) begin
      int unsigned maxu;
      maxu = (mq.size() > 2) ? 2 : mq.size();
      cyc(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0),
          2'($urandom_range(0, maxu)), ($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 1)));
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard3_instr_aligner.md
Name: hazard3_instr_aligner

Overview:
- Halfword-granular instruction buffer directly upstream of the RVC expander.
- Accepts word-aligned 32-bit fetch data from the bus interface and handles misaligned jump targets.
- Presents the oldest two halfwords as a 32-bit window (cir) for the expander and decode.
- Retires 0, 1 or 2 halfwords per cycle, as reported by decode from the expander's length result.

Parameters:
- DEPTH_HW, 6, buffer capacity in halfwords; even, minimum 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- fetch_vld  input  1  fetch word valid.
- fetch_rdy  output  1  buffer can accept a full word this cycle.
- fetch_data  input  32  fetched word; halfword 0 in bits 15:0.
- fetch_err  input  1  bus error for this word; tags both halfwords.
- flush  input  1  jump/trap; discard all buffered and in-flight data.
- flush_addr_hw  input  1  bit 1 of the jump target.
- cir  output  32  oldest halfword in 15:0, next in 31:16; zero in invalid halfwords.
- cir_vld  output  2  valid halfwords in cir: 0, 1 or 2 (min of count and 2).
- cir_err  output  2  per-halfword bus-error tag; bit 0 is cir[15:0].
- cir_use  input  2  halfwords retired this cycle: 0, 1 or 2; value 3 is illegal.

Behaviour:
- State: halfword array buf[0..DEPTH_HW-1] with per-entry error bits; count, 0..DEPTH_HW; drop_lower flag.
- All outputs are functions of registered state only. There is no combinational path from cir_use, fetch_vld or flush to any output.
- Reset: count=0, all buf and error bits 0, drop_lower=0.
  - Hence cir=0, cir_vld=0, cir_err=0, fetch_rdy=1.
- fetch_rdy = (count <= DEPTH_HW-2).
  - This deliberately ignores same-cycle consumption, which cuts the decode->bus timing path.
- Word acceptance requires fetch_vld && fetch_rdy && !flush.
  - Normally appends 2 halfwords.
  - If drop_lower=1, appends only fetch_data[31:16] and clears drop_lower.
- Retire and append in the same cycle:
  - Entries shift down by cir_use.
  - New halfwords are written starting at index count-cir_use.
  - next count = count - cir_use + appended.
- Latency: a word accepted at edge N is visible on cir from cycle N+1, when the buffer was empty before acceptance.
- cir_use > cir_vld is illegal. Add a simulation assertion. The RTL clamps the retire amount to cir_vld.
- 32-bit instruction with cir_vld=1: decode drives cir_use=0 and waits. The aligner does nothing special.
- Flush has priority over all other activity in the cycle:
  - next count=0.
  - Any accepted word is discarded, and any cir_use is ignored.
  - drop_lower is set to flush_addr_hw.
- A flush with flush_addr_hw=0 clears a pending drop_lower.
- Back-to-back flushes: the last one wins.
- Errored halfwords:
  - They are buffered and presented like data, with cir_err set.
  - Data bits are passed through unmodified; the trap decision belongs to decode.
  - An errored word whose lower half is dropped tags only the kept upper half.
- Full: count=DEPTH_HW-1 or DEPTH_HW gives fetch_rdy=0 even if cir_use=2 in the same cycle.
- Empty: cir_vld=0 and cir=0. cir_use must be 0.

Test Plan:
- Reset, then accept 0x0001_4501 → next cycle cir=0x00014501, cir_vld=2, cir_err=0, fetch_rdy=1.
- Buffer holds one halfword 0x4505, then accept 0x8082_0513 with cir_use=0 → cir=0x05134505, count=3; next cycle cir_use=1 → cir=0x80820513.
- flush with flush_addr_hw=1, then fetch 0x4501_8082 → cir_vld=1, cir[15:0]=0x4501, cir[31:16]=0.
- Fill to count=6 with cir_use=0, then fetch_vld=1 → fetch_rdy=0 at count 5 and 6. Drain with cir_use=2 → fetch_rdy returns to 1 once count<=4. No data loss or duplication, checked against a scoreboard of the halfword stream.
- Word accepted in the same cycle as flush (flush_addr_hw=0) → word discarded, count=0 next cycle. Subsequent word 0x12345678 → cir=0x12345678.
- Accept word 0xDEAD_BEEF with fetch_err=1 → cir_err=2'b11, cir=0xDEADBEEF. Repeat after a flush with flush_addr_hw=1 → cir_err=2'b01, cir[15:0]=0xDEAD.
- Random soak: random fetch_vld, legal cir_use and occasional flush against a reference halfword queue → outputs match every cycle and the assertion never fires.
